// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode and aluOp encodings shared by the decode stage
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;
endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, x0 hardwired to zero, write-back bypass on both read ports
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];
  logic        wr;
  assign wr  = we && wa != 5'd0;
  assign rd1 = ra1 == 5'd0 ? '0 : (wr && wa == ra1) ? wd : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : (wr && wa == ra2) ? wd : regs[ra2];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (wr)
      regs[wa] <= wd;
endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode, immediate generation, register read and load-use stall
module id_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic        ex_memRead,
  input  logic [4:0]  ex_rd,
  input  logic        wb_regWrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] pc_out,
  output logic [31:0] reg_data1,
  output logic [31:0] reg_data2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [1:0]  aluOp,
  output logic        aluSrc,
  output logic        memRead,
  output logic        memWrite,
  output logic        branch,
  output logic        memtoReg,
  output logic        regWrite,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        pc_write,
  output logic        if_id_write,
  output logic [31:0] stall_count
);
  logic [6:0]  op;
  ctrl_t       dec, ctrl;
  logic        hazard, stall;
  logic [31:0] stall_q;
  assign op     = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign pc_out = pc_in;
  regfile u_rf (
    .clk(clk), .reset(reset), .ra1(rs1), .ra2(rs2),
    .we(wb_regWrite), .wa(wb_rd), .wd(wb_data), .rd1(reg_data1), .rd2(reg_data2)
  );
  always_comb begin
    dec = '0;
    case (op)
      OP_R:      dec = '{ALUOP_R,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      OP_IMM:    dec = '{ALUOP_I,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      OP_LOAD:   dec = '{ALUOP_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      OP_STORE:  dec = '{ALUOP_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_BRANCH: dec = '{ALUOP_BR,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      default:   dec = '0;
    endcase
  end
  always_comb
    imm = (op == OP_LOAD || op == OP_IMM) ? {{20{instr[31]}}, instr[31:20]} :
          op == OP_STORE  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          op == OP_BRANCH ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          '0;
  // rs2 is compared for every opcode; a spurious stall is harmless
  assign hazard      = ex_memRead && ex_rd != 5'd0 && (ex_rd == rs1 || ex_rd == rs2);
  assign stall       = hazard && !flush && !reset;
  assign ctrl        = (stall || flush || reset) ? '0 : dec;
  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign {aluOp, aluSrc, memRead, memWrite, branch, memtoReg, regWrite} = ctrl;
  assign stall_count = stall_q;
  always_ff @(posedge clk)
    if (reset)
      stall_q <= '0;
    else if (stall && stall_q != '1)
      stall_q <= stall_q + 32'd1;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors with a queue-based scoreboard checked at the falling edge
module tb_id_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] instr = '0, pc_in = '0;
  logic        flush = 1'b0, ex_memRead = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        wb_regWrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] pc_out, reg_data1, reg_data2, imm, stall_count;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  aluOp;
  logic        aluSrc, memRead, memWrite, branch, memtoReg, regWrite, pc_write, if_id_write;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  int          tests = 0, fails = 0;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] imm, d1, d2, pc, cnt;
    logic [14:0] idx;
    logic        stalled;
  } exp_t;
  exp_t q[$];

  id_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .pc_in(pc_in), .flush(flush),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .pc_out(pc_out), .reg_data1(reg_data1), .reg_data2(reg_data2),
    .rs1(rs1), .rs2(rs2), .rd(rd), .aluOp(aluOp), .aluSrc(aluSrc), .memRead(memRead),
    .memWrite(memWrite), .branch(branch), .memtoReg(memtoReg), .regWrite(regWrite),
    .funct3(funct3), .funct7(funct7), .imm(imm), .pc_write(pc_write),
    .if_id_write(if_id_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctrl", {24'd0, aluOp, aluSrc, memRead, memWrite, branch, memtoReg, regWrite}, {24'd0, e.ctrl});
      chk("imm", imm, e.imm);
      chk("reg_data1", reg_data1, e.d1);
      chk("reg_data2", reg_data2, e.d2);
      chk("pc_out", pc_out, e.pc);
      chk("indices", {17'd0, rs1, rs2, rd}, {17'd0, e.idx});
      chk("pc_write", {31'd0, pc_write}, {31'd0, !e.stalled});
      chk("if_id_write", {31'd0, if_id_write}, {31'd0, !e.stalled});
      chk("stall_count", stall_count, e.cnt);
    end

  // drive one cycle of inputs and queue the expected decode outputs for that cycle
  task automatic vec(input logic rst, input logic [31:0] ins, input logic fl, input logic emr,
                     input logic [4:0] erd, input logic we, input logic [4:0] wrd,
                     input logic [31:0] wd, input logic [7:0] ectrl, input logic [31:0] eimm,
                     input logic [31:0] ed1, input logic [31:0] ed2, input logic est,
                     input logic [31:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; instr = ins; flush = fl; ex_memRead = emr; ex_rd = erd;
    wb_regWrite = we; wb_rd = wrd; wb_data = wd; pc_in = pc_in + 32'd4;
    e.ctrl = ectrl; e.imm = eimm; e.d1 = ed1; e.d2 = ed2; e.pc = pc_in;
    e.idx = {ins[19:15], ins[24:20], ins[11:7]}; e.stalled = est; e.cnt = ecnt;
    q.push_back(e);
  endtask

  localparam logic [31:0] ADD_X1_X5_X0 = 32'h000280B3;
  localparam logic [31:0] ADD_X1_X0_X0 = 32'h000000B3;
  localparam logic [31:0] ADD_X1_X7_X5 = 32'h005380B3;
  localparam logic [31:0] LW_X3_8_X2   = 32'h00812183;
  localparam logic [31:0] BEQ_M4       = 32'hFE000EE3;
  localparam logic [31:0] SW_X5_M8     = 32'hFE502C23;
  localparam logic [31:0] ADDI_X1_M1   = 32'hFFF28093;
  localparam logic [31:0] ADD_X4_X3_X1 = 32'h00118233;

  initial begin
    @(posedge clk);
    #1;
    reset = 1'b1; wb_regWrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h11111111;
    // second reset cycle: counter already cleared, write-back still dropped
    vec(1, 32'h0, 0, 0, 0, 1, 5'd5, 32'h11111111, 8'h00, 0, 0, 0, 0, 0);
    vec(0, ADD_X1_X5_X0, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0, 0, 0, 0);
    vec(0, 32'h0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 8'h00, 0, 0, 0, 0, 0);
    vec(0, ADD_X1_X5_X0, 0, 0, 0, 0, 0, 0, 8'h81, 0, 32'hDEADBEEF, 0, 0, 0);
    vec(0, ADD_X1_X0_X0, 0, 0, 0, 1, 5'd0, 32'h1234, 8'h81, 0, 0, 0, 0, 0);
    vec(0, ADD_X1_X0_X0, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0, 0, 0, 0);
    vec(0, ADD_X1_X7_X5, 0, 0, 0, 1, 5'd7, 32'hA5A5A5A5, 8'h81, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0);
    vec(0, LW_X3_8_X2, 0, 0, 0, 0, 0, 0, 8'h33, 32'd8, 0, 0, 0, 0);
    vec(0, BEQ_M4, 0, 0, 0, 0, 0, 0, 8'h44, 32'hFFFFFFFC, 0, 0, 0, 0);
    vec(0, SW_X5_M8, 0, 0, 0, 0, 0, 0, 8'h28, 32'hFFFFFFF8, 0, 32'hDEADBEEF, 0, 0);
    vec(0, ADDI_X1_M1, 0, 0, 0, 0, 0, 0, 8'hE1, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 0, 0);
    vec(0, ADD_X1_X7_X5, 0, 0, 0, 0, 0, 0, 8'h81, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0);
    vec(0, ADD_X4_X3_X1, 0, 1, 5'd3, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    vec(0, ADD_X4_X3_X1, 0, 1, 5'd0, 0, 0, 0, 8'h81, 0, 0, 0, 0, 1);
    vec(0, ADD_X4_X3_X1, 1, 1, 5'd3, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1);
    vec(0, 32'h0000007F, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1);
    vec(0, ADD_X4_X3_X1, 0, 1, 5'd1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1);
    vec(0, ADD_X1_X0_X0, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0, 0, 0, 2);
    @(posedge clk);
    #1;
    dut.stall_q = '1;
    q.delete();
    reset = 1'b0; instr = ADD_X4_X3_X1; ex_memRead = 1'b1; ex_rd = 5'd3;
    vec(0, ADD_X4_X3_X1, 0, 1, 5'd3, 0, 0, 0, 8'h00, 0, 0, 0, 1, 32'hFFFFFFFF);
    vec(0, ADD_X1_X0_X0, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0, 0, 0, 32'hFFFFFFFF);
    vec(1, ADD_X4_X3_X1, 0, 1, 5'd3, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'hFFFFFFFF);
    vec(0, ADD_X1_X5_X0, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
